// File: rtl/vm_pkg.sv
// vm_pkg: definitions shared by the vending machine FSM and the
// change dispenser.
//   vm_disp_state_t - dispenser state encoding
//   *_CENTS         - coin values and product price
//   TIMER_W         - width of the dispenser cycle timer
//   timer_preset()  - converts a cycle count into a timer load value
package vm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_VEND = 3'd1,
      ST_PAY  = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } vm_disp_state_t;

   localparam int NICKLE_CENTS  = 5;
   localparam int DIME_CENTS    = 10;
   localparam int QUARTER_CENTS = 25;
   localparam int PRICE_CENTS   = 20;

   localparam int TIMER_W = 16;

   // The timer expires once it has counted down to zero, so a phase that
   // lasts N cycles is loaded with N-1.
   function automatic logic [TIMER_W-1:0] timer_preset(input int cycles);
      return TIMER_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/vm_cycle_timer.sv
// vm_cycle_timer: loadable down-counter with a zero flag.
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset (count cleared)
//   load       - load load_value this cycle (overrides counting)
//   load_value - value to load
//   expired    - high while the count is zero
module vm_cycle_timer
   import vm_pkg::*;
#(
   parameter int WIDTH = TIMER_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser: runs the product-drop motor after each vend pulse,
// then pays the owed nickels one at a time through a req/ack hopper.
// Holds one follow-on vend request.
//   clk, rst      - clock and synchronous active-high reset
//   soda, change  - vend pulse and nickels owed (change valid with soda)
//   eject_ack     - hopper released one nickel
//   vend_motor    - product-drop motor enable
//   eject_req     - request one nickel from the hopper
//   busy          - dispenser not idle (combinational)
//   done          - one-cycle pulse when a vend and its payout finish
//   overflow_err  - sticky: a vend request was dropped (slot full)
//   hopper_fault  - sticky: the hopper failed to acknowledge in time
//   owed          - nickels left unpaid at the last fault
//   total_nickles - count of nickels ejected, wraps
module vm_change_dispenser
   import vm_pkg::*;
#(
   parameter int VEND_CYCLES = 4,
   parameter int EJECT_GAP   = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        soda,
   input  logic [2:0]  change,
   input  logic        eject_ack,
   output logic        vend_motor,
   output logic        eject_req,
   output logic        busy,
   output logic        done,
   output logic        overflow_err,
   output logic        hopper_fault,
   output logic [2:0]  owed,
   output logic [15:0] total_nickles
);

   vm_disp_state_t state_reg, state_next;

   logic [2:0]  coins_reg, coins_next;
   logic        pend_valid_reg, pend_valid_next;
   logic [2:0]  pend_change_reg, pend_change_next;
   logic [15:0] total_reg, total_next;
   logic        fault_reg, fault_next;
   logic [2:0]  owed_reg, owed_next;
   logic        overflow_reg, overflow_next;
   logic        vend_motor_reg, eject_req_reg, done_reg;

   logic               timer_load;
   logic [TIMER_W-1:0] timer_value;
   logic               timer_expired;

   // One timer serves every timed phase; it is reloaded on each state entry.
   vm_cycle_timer #(.WIDTH(TIMER_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .expired    (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         coins_reg       <= '0;
         pend_valid_reg  <= 1'b0;
         pend_change_reg <= '0;
         total_reg       <= '0;
         fault_reg       <= 1'b0;
         owed_reg        <= '0;
         overflow_reg    <= 1'b0;
         vend_motor_reg  <= 1'b0;
         eject_req_reg   <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         coins_reg       <= coins_next;
         pend_valid_reg  <= pend_valid_next;
         pend_change_reg <= pend_change_next;
         total_reg       <= total_next;
         fault_reg       <= fault_next;
         owed_reg        <= owed_next;
         overflow_reg    <= overflow_next;
         // Decoding the next state keeps these outputs registered yet
         // aligned with the state they belong to.
         vend_motor_reg  <= (state_next == ST_VEND);
         eject_req_reg   <= (state_next == ST_PAY);
         done_reg        <= (state_next == ST_DONE);
      end
   end

   always_comb begin
      state_next       = state_reg;
      coins_next       = coins_reg;
      pend_valid_next  = pend_valid_reg;
      pend_change_next = pend_change_reg;
      total_next       = total_reg;
      fault_next       = fault_reg;
      owed_next        = owed_reg;
      overflow_next    = overflow_reg;
      timer_value      = '0;

      case (state_reg)
         ST_IDLE: begin
            if (soda) begin
               coins_next = change;
               state_next = ST_VEND;
            end
         end
         ST_VEND: begin
            if (timer_expired) begin
               state_next = (coins_reg != 3'd0) ? ST_PAY : ST_DONE;
            end
         end
         ST_PAY: begin
            // An ack arriving in the final timeout cycle still counts.
            if (eject_ack) begin
               coins_next = coins_reg - 3'd1;
               total_next = total_reg + 16'd1;
               state_next = (coins_reg == 3'd1) ? ST_DONE : ST_GAP;
            end else if (timer_expired) begin
               fault_next = 1'b1;
               owed_next  = coins_reg;
               coins_next = 3'd0;
               state_next = ST_DONE;
            end
         end
         ST_GAP: begin
            if (timer_expired) begin
               state_next = ST_PAY;
            end
         end
         ST_DONE: begin
            if (pend_valid_reg) begin
               coins_next      = pend_change_reg;
               pend_valid_next = 1'b0;
               state_next      = ST_VEND;
            end else if (soda) begin
               // Empty slot: the request would be stored and served at
               // once, so it bypasses the slot.
               coins_next = change;
               state_next = ST_VEND;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Requests arriving while busy go to the single pending slot.
      if (soda && (state_reg != ST_IDLE)) begin
         if (pend_valid_reg) begin
            overflow_next = 1'b1;
         end else if (state_reg != ST_DONE) begin
            pend_valid_next  = 1'b1;
            pend_change_next = change;
         end
      end

      timer_load = (state_next != state_reg);
      case (state_next)
         ST_VEND: timer_value = timer_preset(VEND_CYCLES);
         ST_PAY:  timer_value = timer_preset(ACK_TIMEOUT);
         ST_GAP:  timer_value = timer_preset(EJECT_GAP);
         default: timer_value = '0;
      endcase
   end

   assign busy          = (state_reg != ST_IDLE);
   assign vend_motor    = vend_motor_reg;
   assign eject_req     = eject_req_reg;
   assign done          = done_reg;
   assign overflow_err  = overflow_reg;
   assign hopper_fault  = fault_reg;
   assign owed          = owed_reg;
   assign total_nickles = total_reg;

endmodule

// File: tb/tb_vm_change_dispenser.sv
module tb_vm_change_dispenser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        soda = 1'b0;
   logic [2:0]  change = 3'd0;
   logic        eject_ack = 1'b0;
   logic        vend_motor, eject_req, busy, done;
   logic        overflow_err, hopper_fault;
   logic [2:0]  owed;
   logic [15:0] total_nickles;

   vm_change_dispenser #(
      .VEND_CYCLES (4),
      .EJECT_GAP   (2),
      .ACK_TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .soda          (soda),
      .change        (change),
      .eject_ack     (eject_ack),
      .vend_motor    (vend_motor),
      .eject_req     (eject_req),
      .busy          (busy),
      .done          (done),
      .overflow_err  (overflow_err),
      .hopper_fault  (hopper_fault),
      .owed          (owed),
      .total_nickles (total_nickles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] total;
      logic        fault;
      logic [2:0]  owed;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Hopper model controls and monitor statistics.
   int ack_delay  = 2;
   int ack_budget = 1000;
   int req_age    = 0;
   int done_count = 0;
   int motor_cycles = 0;
   int req_rises  = 0;
   int req_run    = 0;
   int last_req_len = 0;
   logic req_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic pulse_soda(input logic [2:0] c, input bit expect_done,
                             input logic [15:0] tot, input logic flt, input logic [2:0] ow);
      @(negedge clk);
      soda   = 1'b1;
      change = c;
      if (expect_done) sb.push_back('{total: tot, fault: flt, owed: ow});
      $display("soda change=%0d queued=%0d", c, expect_done);
      @(negedge clk);
      soda   = 1'b0;
      change = 3'd0;
   endtask

   task automatic wait_done(input int target, input string tag);
      for (int i = 0; i < 400 && done_count < target; i++) @(negedge clk);
      check(tag, 32'(done_count >= target), 32'd1);
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 100 && !eject_req; i++) @(negedge clk);
      check(tag, 32'(eject_req), 32'd1);
   endtask

   initial begin
      int base_done, base_motor, base_rises;

      fork
         // Hopper: acknowledges the request in its ack_delay-th cycle.
         forever begin
            @(posedge clk);
            #1;
            if (eject_req && !rst) begin
               req_age++;
               if (req_age == ack_delay && ack_budget > 0) begin
                  eject_ack = 1'b1;
                  ack_budget--;
               end else begin
                  eject_ack = 1'b0;
               end
            end else begin
               req_age   = 0;
               eject_ack = 1'b0;
            end
         end
         // Monitor: statistics plus scoreboard check on every done pulse.
         forever begin
            @(posedge clk);
            #1;
            if (vend_motor) motor_cycles++;
            if (eject_req && !req_prev) req_rises++;
            if (eject_req) req_run++;
            else if (req_prev) begin
               last_req_len = req_run;
               req_run = 0;
            end
            req_prev = eject_req;
            if (done) begin
               done_count++;
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  $display("done total=%0d fault=%0d owed=%0d", total_nickles, hopper_fault, owed);
                  check("done_total", 32'(total_nickles), 32'(e.total));
                  check("done_fault", 32'(hopper_fault), 32'(e.fault));
                  check("done_owed", 32'(owed), 32'(e.owed));
               end
            end
         end
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      do_reset();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_outs", {24'd0, vend_motor, eject_req, done, overflow_err, hopper_fault, owed}, 32'd0);
      check("rst_total", 32'(total_nickles), 32'd0);

      // 1: four nickels, ack two cycles after each request
      base_done = done_count; base_motor = motor_cycles; base_rises = req_rises;
      pulse_soda(3'd4, 1'b1, 16'd4, 1'b0, 3'd0);
      check("t1_motor_first", 32'(vend_motor), 32'd1);
      wait_done(base_done + 1, "t1_done_wait");
      check("t1_motor_cycles", 32'(motor_cycles - base_motor), 32'd4);
      check("t1_req_pairs", 32'(req_rises - base_rises), 32'd4);
      check("t1_total", 32'(total_nickles), 32'd4);

      // 2: no change; done at N+5, idle at N+6
      do_reset();
      base_rises = req_rises;
      pulse_soda(3'd0, 1'b1, 16'd0, 1'b0, 3'd0);
      repeat (3) @(negedge clk);
      check("t2_motor_last", 32'(vend_motor), 32'd1);
      @(negedge clk);
      check("t2_done_n5", 32'(done), 32'd1);
      check("t2_motor_off", 32'(vend_motor), 32'd0);
      @(negedge clk);
      check("t2_busy_n6", 32'(busy), 32'd0);
      check("t2_no_req", 32'(req_rises - base_rises), 32'd0);

      // 3: follow-on vend queued during VEND
      do_reset();
      base_done = done_count;
      pulse_soda(3'd2, 1'b1, 16'd2, 1'b0, 3'd0);
      pulse_soda(3'd3, 1'b1, 16'd5, 1'b0, 3'd0);
      wait_done(base_done + 1, "t3_first_done");
      @(negedge clk);
      check("t3_back_to_back", 32'(vend_motor), 32'd1);
      wait_done(base_done + 2, "t3_second_done");
      check("t3_total", 32'(total_nickles), 32'd5);
      check("t3_overflow", 32'(overflow_err), 32'd0);

      // 4: second request buffered, third dropped
      do_reset();
      base_done = done_count;
      pulse_soda(3'd2, 1'b1, 16'd2, 1'b0, 3'd0);
      wait_req("t4_pay_wait");
      pulse_soda(3'd1, 1'b1, 16'd3, 1'b0, 3'd0);
      check("t4_no_overflow_yet", 32'(overflow_err), 32'd0);
      pulse_soda(3'd1, 1'b0, 16'd0, 1'b0, 3'd0);
      check("t4_overflow", 32'(overflow_err), 32'd1);
      wait_done(base_done + 2, "t4_done_wait");
      repeat (40) @(negedge clk);
      check("t4_done_count", 32'(done_count - base_done), 32'd2);
      check("t4_overflow_sticky", 32'(overflow_err), 32'd1);

      // 5: first coin acked, then the hopper goes silent
      do_reset();
      base_done = done_count;
      ack_budget = 1;
      pulse_soda(3'd3, 1'b1, 16'd1, 1'b1, 3'd2);
      wait_done(base_done + 1, "t5_done_wait");
      check("t5_timeout_len", 32'(last_req_len), 32'd16);
      check("t5_fault", 32'(hopper_fault), 32'd1);
      check("t5_owed", 32'(owed), 32'd2);
      @(negedge clk);
      check("t5_idle", 32'(busy), 32'd0);

      // 6: reset in the middle of a payout
      ack_budget = 1000;
      pulse_soda(3'd3, 1'b1, 16'd0, 1'b0, 3'd0);
      wait_req("t6_pay_wait");
      do_reset();
      check("t6_req_low", 32'(eject_req), 32'd0);
      check("t6_busy_low", 32'(busy), 32'd0);
      check("t6_flags", {28'd0, hopper_fault, overflow_err, owed == 3'd0, 1'b0}, 32'd2);
      check("t6_total", 32'(total_nickles), 32'd0);
      base_done = done_count;
      pulse_soda(3'd1, 1'b1, 16'd1, 1'b0, 3'd0);
      wait_done(base_done + 1, "t6_served");

      // 7: ack in the very last timeout cycle beats the timeout
      ack_delay = 16;
      base_done = done_count;
      pulse_soda(3'd2, 1'b1, 16'd3, 1'b0, 3'd0);
      wait_done(base_done + 1, "t7_done_wait");
      check("t7_req_len", 32'(last_req_len), 32'd16);
      check("t7_no_fault", 32'(hopper_fault), 32'd0);
      check("t7_total", 32'(total_nickles), 32'd3);

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
